// File: rtl/spike_rate_decoder.sv
// Spike-train to rate decoder: counts spikes over WINDOW_LEN enabled cycles into a one-entry valid/ready buffer.
// Optional inter-spike-interval measurement is built when SPIKE_DECODER_ISI_EN is defined.
module spike_rate_decoder #(
  parameter int unsigned WINDOW_LEN = 256,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned ISI_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             spike,
  output logic [CNT_W-1:0] rate,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic             overrun,
  output logic [ISI_W-1:0] isi,
  output logic             isi_valid
);

  localparam int unsigned WCNT_W = $clog2(WINDOW_LEN);
  localparam int unsigned SUM_W  = CNT_W + 1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state;
  logic [WCNT_W-1:0] wcnt;
  logic [CNT_W-1:0]  acc;
  logic [SUM_W-1:0]  acc_sum_c;
  logic [CNT_W-1:0]  acc_next_c;
  logic              win_end_c;

  // Saturating accumulate including the current sample; window closes on the last enabled cycle.
  always_comb begin
    acc_sum_c  = {1'b0, acc} + SUM_W'(spike);
    acc_next_c = acc_sum_c[CNT_W] ? '1 : acc_sum_c[CNT_W-1:0];
    win_end_c  = ena && (wcnt == WCNT_W'(WINDOW_LEN - 1));
  end

  // Window position and spike accumulator; frozen while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
      acc  <= '0;
    end else if (ena) begin
      if (win_end_c) begin
        wcnt <= '0;
        acc  <= '0;
      end else begin
        wcnt <= wcnt + WCNT_W'(1);
        acc  <= acc_next_c;
      end
    end
  end

  // One-entry output buffer: a load always wins, overwriting an unconsumed result flags overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      rate    <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (state == EMPTY) begin
        if (win_end_c) begin
          rate  <= acc_next_c;
          state <= FULL;
        end
      end else begin
        if (win_end_c) begin
          rate    <= acc_next_c;
          overrun <= !rate_ready;
        end else if (rate_ready) begin
          state <= EMPTY;
        end
      end
    end
  end

  assign rate_valid = (state == FULL);

`ifdef SPIKE_DECODER_ISI_EN
  localparam int unsigned ISUM_W = ISI_W + 1;

  logic [ISI_W-1:0]  icnt;
  logic              seen;
  logic [ISUM_W-1:0] icnt_sum_c;
  logic [ISI_W-1:0]  icnt_inc_c;

  always_comb begin
    icnt_sum_c = {1'b0, icnt} + ISUM_W'(1);
    icnt_inc_c = icnt_sum_c[ISI_W] ? '1 : icnt_sum_c[ISI_W-1:0];
  end

  // Interval is only meaningful once a previous spike has been seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icnt      <= '0;
      seen      <= 1'b0;
      isi       <= '0;
      isi_valid <= 1'b0;
    end else if (ena) begin
      if (spike) begin
        isi       <= icnt_inc_c;
        icnt      <= '0;
        seen      <= 1'b1;
        isi_valid <= seen;
      end else begin
        icnt <= icnt_inc_c;
      end
    end
  end
`else
  assign isi       = '0;
  assign isi_valid = 1'b0;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder: directed sequences, a window table and randomized traffic
// against an integer-arithmetic reference model (WINDOW_LEN=16, CNT_W=8 plus a CNT_W=4 instance).
module tb_spike_rate_decoder;

  localparam int unsigned WL = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       spike;
  logic       rate_ready;
  logic       rate_ready4;
  logic [7:0] rate;
  logic       rate_valid;
  logic       overrun;
  logic [7:0] isi;
  logic       isi_valid;
  logic [3:0] rate4;
  logic       rate_valid4;
  logic       overrun4;
  logic [7:0] isi4;
  logic       isi_valid4;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_pos, m_cnt, m_rate, m_rate4;
  bit m_valid, m_valid4, m_ovr;
  int m_ecount, m_last, m_isi;
  bit m_isi_valid;

  typedef struct {
    int nspk;
    bit rdy;
    int exp_rate;
    bit exp_valid;
    bit exp_ovr;
  } win_vec_t;

  win_vec_t tbl [5];

  always #5 clk = ~clk;

  spike_rate_decoder #(.WINDOW_LEN(WL), .CNT_W(8), .ISI_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .spike(spike),
    .rate(rate), .rate_valid(rate_valid), .rate_ready(rate_ready),
    .overrun(overrun), .isi(isi), .isi_valid(isi_valid)
  );

  spike_rate_decoder #(.WINDOW_LEN(WL), .CNT_W(4), .ISI_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .spike(spike),
    .rate(rate4), .rate_valid(rate_valid4), .rate_ready(rate_ready4),
    .overrun(overrun4), .isi(isi4), .isi_valid(isi_valid4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_cnt = 0; m_rate = 0; m_rate4 = 0;
    m_valid = 0; m_valid4 = 0; m_ovr = 0;
    m_ecount = 0; m_last = -1; m_isi = 0; m_isi_valid = 0;
  endtask

  task automatic compare_all();
    int exp_isi;
    bit exp_iv;
`ifdef SPIKE_DECODER_ISI_EN
    exp_isi = m_isi;
    exp_iv  = m_isi_valid;
`else
    exp_isi = 0;
    exp_iv  = 0;
`endif
    check("rate", 32'(rate), 32'(m_rate));
    check("rate_valid", 32'(rate_valid), 32'(m_valid));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("rate4", 32'(rate4), 32'(m_rate4));
    check("rate_valid4", 32'(rate_valid4), 32'(m_valid4));
    check("overrun4", 32'(overrun4), 32'd0);
    check("isi", 32'(isi), 32'(exp_isi));
    check("isi_valid", 32'(isi_valid), 32'(exp_iv));
  endtask

  // One clock with the given inputs, model advanced from the rules, outputs compared 1 time unit after the edge.
  task automatic step(input bit e, input bit s, input bit r);
    bit load;
    ena = e; spike = s; rate_ready = r;
    @(posedge clk);
    load  = e && (m_pos == WL - 1);
    m_ovr = 0;
    if (load) begin
      if (m_valid && !r) m_ovr = 1;
      m_rate   = (m_cnt + s > 255) ? 255 : m_cnt + s;
      m_rate4  = (m_cnt + s > 15) ? 15 : m_cnt + s;
      m_valid  = 1;
      m_valid4 = 1;
      m_cnt    = 0;
      m_pos    = 0;
    end else begin
      if (m_valid && r) m_valid = 0;
      m_valid4 = 0;
      if (e) begin
        m_cnt += s;
        m_pos++;
      end
    end
    if (e) begin
      if (s) begin
        m_isi       = (m_ecount - m_last > 255) ? 255 : m_ecount - m_last;
        m_isi_valid = (m_last >= 0);
        m_last      = m_ecount;
      end
      m_ecount++;
    end
    #1;
    compare_all();
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_rate"}, 32'(rate), 32'd0);
    check({tag, "_valid"}, 32'(rate_valid), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
    check({tag, "_isi"}, 32'(isi), 32'd0);
    check({tag, "_isi_valid"}, 32'(isi_valid), 32'd0);
    check({tag, "_rate4"}, 32'(rate4), 32'd0);
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; spike = 1'b0; rate_ready = 1'b0; rate_ready4 = 1'b1;
    model_reset();
    #12;
    do_reset("init");

    // Full window of spikes with ready high: valid one cycle after the 16th sample, drops next cycle.
    for (int c = 0; c < WL; c++) begin
      step(1, 1, 1);
      if (c == WL - 2) check("full_latency_valid", 32'(rate_valid), 32'd0);
    end
    check("full_rate", 32'(rate), 32'd16);
    check("full_valid", 32'(rate_valid), 32'd1);
    check("sat_rate4", 32'(rate4), 32'd15);
    check("sat_overrun4", 32'(overrun4), 32'd0);
    step(0, 0, 1);
    check("full_drop_valid", 32'(rate_valid), 32'd0);
    check("full_hold_rate", 32'(rate), 32'd16);

    // Reset mid-window after 7 spikes discards the partial count.
    for (int c = 0; c < 7; c++) step(1, 1, 0);
    do_reset("midrst");
    for (int c = 0; c < WL; c++) step(1, c < 3, 0);
    check("midrst_rate", 32'(rate), 32'd3);
    check("midrst_valid", 32'(rate_valid), 32'd1);

    // Window table: spike count and ready level per window, expectations at the load cycle.
    tbl[0] = '{5,  1'b0, 5,  1'b1, 1'b0};
    tbl[1] = '{3,  1'b0, 3,  1'b1, 1'b1};
    tbl[2] = '{16, 1'b1, 16, 1'b1, 1'b0};
    tbl[3] = '{0,  1'b1, 0,  1'b1, 1'b0};
    tbl[4] = '{7,  1'b0, 7,  1'b1, 1'b1};
    do_reset("tbl");
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < WL; c++) step(1, c < tbl[i].nspk, tbl[i].rdy);
      check($sformatf("tbl%0d_rate", i), 32'(rate), 32'(tbl[i].exp_rate));
      check($sformatf("tbl%0d_valid", i), 32'(rate_valid), 32'(tbl[i].exp_valid));
      check($sformatf("tbl%0d_overrun", i), 32'(overrun), 32'(tbl[i].exp_ovr));
    end
    step(0, 0, 0);
    check("ovr_one_cycle", 32'(overrun), 32'd0);
    check("ovr_valid_held", 32'(rate_valid), 32'd1);

    // ena low for 10 cycles mid-window freezes the window and ignores spikes.
    do_reset("freeze");
    for (int c = 0; c < 4; c++) step(1, 1, 0);
    for (int c = 0; c < 10; c++) step(0, 1, 0);
    for (int c = 0; c < 2; c++) step(1, 0, 0);
    check("freeze_not_closed", 32'(rate_valid), 32'd0);
    for (int c = 0; c < 10; c++) step(1, 0, 0);
    check("freeze_closed", 32'(rate_valid), 32'd1);
    check("freeze_rate", 32'(rate), 32'd4);

    // Inter-spike interval: spikes at enabled cycles 0 and 5, then 6 and 7.
    do_reset("isi");
    for (int c = 0; c < 8; c++) begin
      step(1, (c == 0) || (c >= 5), 1);
`ifdef SPIKE_DECODER_ISI_EN
      if (c == 5) begin
        check("isi_5", 32'(isi), 32'd5);
        check("isi_5_valid", 32'(isi_valid), 32'd1);
      end
      if (c == 7) check("isi_1", 32'(isi), 32'd1);
`else
      if (c == 5 || c == 7) begin
        check("isi_off", 32'(isi), 32'd0);
        check("isi_off_valid", 32'(isi_valid), 32'd0);
      end
`endif
    end

    // Randomized traffic against the model.
    do_reset("rand");
    for (int c = 0; c < 600; c++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
